mc_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the RV32I core, replacing the fixed-latency controller. It drives every datapath enable and mux select in the core's top level, adds request/acknowledge handshakes to instruction and data memory so variable-latency memories and peripherals are tolerated, and detects illegal opcodes and bus timeouts. It also maintains a retired-instruction counter.

---
 rtl/mc_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer for the RV32I core: drives datapath enables/selects and memory handshakes.
// Latency: FETCH-to-FETCH 3 (LUI), 4 (ALU/branch/jump/AUIPC/STORE), 5 (LOAD) cycles plus one per wait cycle.
// Backpressure: FETCH and MEM hold until imem_ack/dmem_ack; a bounded wait ends in a sticky FAULT.
module mc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h00001000,
    parameter int          MEM_TIMEOUT = 15,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_wren,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       writeback_src,
    output logic [31:0]      reset_pc,
    output logic [2:0]       state,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Counter only needs to reach MEM_TIMEOUT; it saturates there so it never wraps.
    localparam int                WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [2:0]        state_q, state_nxt;
    logic [1:0]        cause_q, cause_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instret_q;
    logic              timeout_hit;
    logic              op_legal;
    logic [3:0]        alu_sel;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_MAX);

    // Legal-opcode decode for the DECODE-state fault check.
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    // ALU operand selects per opcode, {alu_src_a, alu_src_b}; kept valid through MEM/WB so ALU result stays stable.
    always_comb begin
        alu_sel = 4'b0000;
        case (opcode)
            OP_R, OP_BRANCH:                 alu_sel = 4'b01_00;
            OP_I, OP_LOAD, OP_STORE, OP_JALR: alu_sel = 4'b01_10;
            OP_JAL, OP_AUIPC:                alu_sel = 4'b00_10;
            default:                         alu_sel = 4'b0000;
        endcase
    end

    // Next-state and fault-cause selection; an ack always beats a same-cycle timeout.
    always_comb begin
        state_nxt = state_q;
        cause_nxt = cause_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    state_nxt = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_FAULT;
                    cause_nxt = 2'b10;
                end
            end
            S_DECODE: begin
                if (!op_legal) begin
                    state_nxt = S_FAULT;
                    cause_nxt = 2'b01;
                end else if (opcode == OP_LUI) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC:  state_nxt = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack) begin
                    state_nxt = (opcode == OP_STORE) ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_nxt = S_FAULT;
                    cause_nxt = 2'b11;
                end
            end
            S_WB:    state_nxt = S_FETCH;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // State, cause, wait counter and retired-instruction count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            cause_q   <= 2'b00;
            wait_cnt  <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_nxt;
            cause_q <= cause_nxt;
            if (state_nxt != state_q) begin
                wait_cnt <= '0;
            end else if ((state_q == S_FETCH || state_q == S_MEM) && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (pc_write) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    // Control outputs decoded from state and opcode; everything is held low while reset is asserted.
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_wren     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        writeback_src = 2'b00;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                end
                S_EXEC: begin
                    {alu_src_a, alu_src_b} = alu_sel;
                end
                S_MEM: begin
                    {alu_src_a, alu_src_b} = alu_sel;
                    dmem_req  = 1'b1;
                    dmem_wren = (opcode == OP_STORE);
                    pc_write  = (opcode == OP_STORE) && dmem_ack;
                end
                S_WB: begin
                    {alu_src_a, alu_src_b} = alu_sel;
                    pc_write = 1'b1;
                    case (opcode)
                        OP_LOAD: begin
                            reg_write     = 1'b1;
                            writeback_src = 2'b01;
                        end
                        OP_LUI: begin
                            reg_write     = 1'b1;
                            writeback_src = 2'b10;
                        end
                        OP_JAL, OP_JALR: begin
                            reg_write     = 1'b1;
                            writeback_src = 2'b11;
                            pc_src        = 1'b1;
                        end
                        OP_BRANCH: begin
                            pc_src = branch_taken;
                        end
                        default: begin
                            reg_write = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign reset_pc    = RESET_PC;
    assign state       = state_q;
    assign fault       = (state_q == S_FAULT);
    assign fault_cause = cause_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer with a short bus timeout (MEM_TIMEOUT = 4).
// Latency: inputs driven just after the falling edge, outputs sampled 1 time unit later.
// Backpressure: acks are held low for chosen cycle counts to exercise wait and timeout paths.
module tb_mc_sequencer;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_wren, ir_write, pc_write, reg_write, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, writeback_src, fault_cause;
    logic [31:0] reset_pc;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    mc_sequencer #(
        .RESET_PC    (32'h00001000),
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .imem_ack      (imem_ack),
        .dmem_ack      (dmem_ack),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .dmem_wren     (dmem_wren),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .writeback_src (writeback_src),
        .reset_pc      (reset_pc),
        .state         (state),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    // Advance to the next cycle's sampling point.
    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    // Pulse reset for two cycles; returns in the first FETCH cycle after release.
    task automatic apply_reset();
        reset    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        opcode   = OP_ADD;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
        n_checks++; if ({imem_req, dmem_req, dmem_wren, ir_write, pc_write, reg_write} !== 6'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 000000", {imem_req, dmem_req, dmem_wren, ir_write, pc_write, reg_write}); end
        n_checks++; if (instret !== 32'd0 || fault !== 1'b0 || fault_cause !== 2'b00) begin n_fail++; $display("FAIL rst_status: instret %0d fault %b cause %b want 0 0 00", instret, fault, fault_cause); end
        n_checks++; if (reset_pc !== 32'h00001000) begin n_fail++; $display("FAIL rst_pc: got %h want 00001000", reset_pc); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || state !== 3'd0) begin n_fail++; $display("FAIL rst_release: imem_req %b state %0d want 1 0", imem_req, state); end
    endtask

    task automatic test_add();
        opcode = OP_ADD; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || ir_write !== 1'b1) begin n_fail++; $display("FAIL add_fetch: imem_req %b ir_write %b want 1 1", imem_req, ir_write); end
        nc();
        n_checks++; if (state !== 3'd1 || {ir_write, pc_write, reg_write, imem_req, dmem_req} !== 5'b0) begin n_fail++; $display("FAIL add_decode: state %0d en %b want 1 00000", state, {ir_write, pc_write, reg_write, imem_req, dmem_req}); end
        nc();
        n_checks++; if (state !== 3'd2 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin n_fail++; $display("FAIL add_exec: state %0d a %b b %b want 2 01 00", state, alu_src_a, alu_src_b); end
        nc();
        n_checks++; if (state !== 3'd4 || reg_write !== 1'b1 || writeback_src !== 2'b00 || pc_write !== 1'b1 || pc_src !== 1'b0) begin n_fail++; $display("FAIL add_wb: state %0d rw %b wb %b pcw %b pcs %b want 4 1 00 1 0", state, reg_write, writeback_src, pc_write, pc_src); end
        n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL add_instret_pre: got %0d want 0", instret); end
        nc();
        n_checks++; if (state !== 3'd0 || instret !== 32'd1) begin n_fail++; $display("FAIL add_retire: state %0d instret %0d want 0 1", state, instret); end
    endtask

    task automatic test_lw_wait();
        int dreq = 0;
        int bad  = 0;
        opcode = OP_LW; imem_ack = 1'b1; dmem_ack = 1'b0;
        #1;
        n_checks++; if (ir_write !== 1'b1) begin n_fail++; $display("FAIL lw_fetch: ir_write %b want 1", ir_write); end
        nc();
        nc();
        n_checks++; if (state !== 3'd2 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_exec: state %0d a %b b %b dreq %b want 2 01 10 0", state, alu_src_a, alu_src_b, dmem_req); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_ack = (i == 3);
            #1;
            if (dmem_req === 1'b1 && state === 3'd3) dreq++;
            if (dmem_wren !== 1'b0 || pc_write !== 1'b0) bad++;
        end
        n_checks++; if (dreq != 4) begin n_fail++; $display("FAIL lw_dreq_cycles: got %0d want 4", dreq); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lw_mem_ctrl: %0d cycles with wren/pc_write set, want 0", bad); end
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        n_checks++; if (state !== 3'd4 || writeback_src !== 2'b01 || reg_write !== 1'b1 || pc_write !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_wb: state %0d wb %b rw %b pcw %b dreq %b want 4 01 1 1 0", state, writeback_src, reg_write, pc_write, dmem_req); end
        nc();
        n_checks++; if (state !== 3'd0 || instret !== 32'd2) begin n_fail++; $display("FAIL lw_retire: state %0d instret %0d want 0 2", state, instret); end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            opcode = OP_BEQ; imem_ack = 1'b1; branch_taken = t[0];
            #1;
            nc();
            nc();
            n_checks++; if (alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin n_fail++; $display("FAIL beq%0d_exec: a %b b %b want 01 00", t, alu_src_a, alu_src_b); end
            nc();
            n_checks++; if (state !== 3'd4 || pc_src !== t[0] || reg_write !== 1'b0 || pc_write !== 1'b1) begin n_fail++; $display("FAIL beq%0d_wb: state %0d pcs %b rw %b pcw %b want 4 %0d 0 1", t, state, pc_src, reg_write, pc_write, t); end
            nc();
        end
        n_checks++; if (state !== 3'd0 || instret !== 32'd4) begin n_fail++; $display("FAIL beq_retire: state %0d instret %0d want 0 4", state, instret); end
    endtask

    task automatic test_back_to_back();
        opcode = OP_LUI; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        nc();
        nc();
        n_checks++; if (state !== 3'd4 || writeback_src !== 2'b10 || reg_write !== 1'b1 || pc_src !== 1'b0) begin n_fail++; $display("FAIL lui_wb: state %0d wb %b rw %b pcs %b want 4 10 1 0", state, writeback_src, reg_write, pc_src); end
        nc();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL lui_latency: state %0d want 0", state); end
        opcode = OP_SW;
        #1;
        nc();
        nc();
        n_checks++; if (state !== 3'd2 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin n_fail++; $display("FAIL sw_exec: state %0d a %b b %b want 2 01 10", state, alu_src_a, alu_src_b); end
        nc();
        n_checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_wren !== 1'b1 || pc_write !== 1'b1 || pc_src !== 1'b0 || reg_write !== 1'b0) begin n_fail++; $display("FAIL sw_mem: state %0d dreq %b wren %b pcw %b pcs %b rw %b want 3 1 1 1 0 0", state, dmem_req, dmem_wren, pc_write, pc_src, reg_write); end
        nc();
        n_checks++; if (state !== 3'd0 || instret !== 32'd6) begin n_fail++; $display("FAIL b2b_retire: state %0d instret %0d want 0 6", state, instret); end
    endtask

    task automatic test_reset_mid_mem();
        opcode = OP_SW; imem_ack = 1'b1; dmem_ack = 1'b0;
        #1;
        nc();
        nc();
        nc();
        n_checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_wren !== 1'b1) begin n_fail++; $display("FAIL swrst_mem: state %0d dreq %b wren %b want 3 1 1", state, dmem_req, dmem_wren); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0 || dmem_wren !== 1'b0 || pc_write !== 1'b0 || state !== 3'd0 || instret !== 32'd0) begin n_fail++; $display("FAIL swrst_drop: dreq %b wren %b pcw %b state %0d instret %0d want 0 0 0 0 0", dmem_req, dmem_wren, pc_write, state, instret); end
        dmem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (state !== 3'd0 || instret !== 32'd0 || imem_req !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL swrst_release: state %0d instret %0d ireq %b dreq %b want 0 0 1 0", state, instret, imem_req, dmem_req); end
    endtask

    task automatic test_illegal();
        logic [31:0] i0;
        int bad = 0;
        opcode = 7'b1111111; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        i0 = instret;
        nc();
        n_checks++; if (state !== 3'd1 || fault !== 1'b0) begin n_fail++; $display("FAIL ill_decode: state %0d fault %b want 1 0", state, fault); end
        nc();
        n_checks++; if (state !== 3'd7 || fault !== 1'b1 || fault_cause !== 2'b01) begin n_fail++; $display("FAIL ill_fault: state %0d fault %b cause %b want 7 1 01", state, fault, fault_cause); end
        for (int i = 0; i < 20; i++) begin
            nc();
            if ({ir_write, pc_write, reg_write, imem_req, dmem_req, dmem_wren} !== 6'b0 || state !== 3'd7 || fault_cause !== 2'b01) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ill_hold: %0d bad cycles want 0", bad); end
        n_checks++; if (instret !== i0) begin n_fail++; $display("FAIL ill_instret: got %0d want %0d", instret, i0); end
    endtask

    task automatic test_imem_timeout();
        int cnt = 0;
        apply_reset();
        opcode = OP_LW; imem_ack = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nc();
            if (imem_req === 1'b1 && state === 3'd0 && fault === 1'b0) cnt++;
        end
        n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL ito_wait: %0d fetch cycles want 5", cnt); end
        nc();
        n_checks++; if (state !== 3'd7 || fault_cause !== 2'b10 || imem_req !== 1'b0) begin n_fail++; $display("FAIL ito_fault: state %0d cause %b ireq %b want 7 10 0", state, fault_cause, imem_req); end
    endtask

    task automatic test_ack_at_limit_and_dmem_timeout();
        int cnt = 0;
        apply_reset();
        opcode = OP_LW; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        nc();
        nc();
        nc();
        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        n_checks++; if (ir_write !== 1'b1 || state !== 3'd0) begin n_fail++; $display("FAIL lim_ack: ir_write %b state %0d want 1 0", ir_write, state); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++; if (state !== 3'd1 || fault !== 1'b0) begin n_fail++; $display("FAIL lim_nofault: state %0d fault %b want 1 0", state, fault); end
        nc();
        for (int i = 0; i < 5; i++) begin
            nc();
            if (dmem_req === 1'b1 && state === 3'd3) cnt++;
        end
        n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL dto_wait: %0d mem cycles want 5", cnt); end
        nc();
        n_checks++; if (state !== 3'd7 || fault_cause !== 2'b11 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL dto_fault: state %0d cause %b dreq %b want 7 11 0", state, fault_cause, dmem_req); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_back_to_back();
        test_reset_mid_mem();
        test_illegal();
        test_imem_timeout();
        test_ack_at_limit_and_dmem_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
